// File: rtl/game_pkg.sv
// Shared types, widths and arithmetic helpers for the game session controller.
package game_pkg;

  localparam int BCD_W      = 4;
  localparam int SCORE_W    = 7;
  localparam int MAX_DIGITS = 11;
  localparam int SUM_W      = BCD_W * MAX_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_T = 3'd1,
    S_WAIT_O = 3'd2,
    S_READ   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  // Sum of up to MAX_DIGITS BCD digits; unused upper digits must be zero.
  // The largest possible sum (11 * 9 = 99) fits in a score-width value.
  function automatic logic [SCORE_W-1:0] bcd_digit_sum(input logic [SUM_W-1:0] digits);
    logic [SCORE_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      sum = sum + SCORE_W'(digits[BCD_W*i +: BCD_W]);
    end
    return sum;
  endfunction

  // Binary 0..99 to two BCD digits {tens, ones}.
  function automatic logic [2*BCD_W-1:0] to_bcd(input logic [SCORE_W-1:0] v);
    logic [BCD_W-1:0]   tens;
    logic [SCORE_W-1:0] rem;
    tens = '0;
    for (int i = 1; i <= 9; i++) begin
      if (v >= SCORE_W'(i * 10)) tens = BCD_W'(i);
    end
    rem = v - SCORE_W'(tens) * SCORE_W'(10);
    return {tens, rem[BCD_W-1:0]};
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] max);
    return (s >= max) ? max : s + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
    return (s == '0) ? '0 : s - SCORE_W'(1);
  endfunction

endpackage

// File: rtl/score_ram.sv
// Per-player score table: synchronous read, synchronous write, cleared by reset.
module score_ram
  import game_pkg::*;
#(
  parameter int ID_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rd_en,
  input  logic [ID_W-1:0]    i_rd_addr,
  output logic [SCORE_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [ID_W-1:0]    i_wr_addr,
  input  logic [SCORE_W-1:0] i_wr_data
);

  localparam int DEPTH = 2 ** ID_W;

  logic [SCORE_W-1:0] r_mem [DEPTH];
  logic [SCORE_W-1:0] r_rd_data;

  // Write port and registered read port; every entry returns to zero on reset.
  // NOTE: the whole array is reset because a reset must wipe every player's
  // score; this rules out a RAM macro, which is acceptable at 2**ID_W x 7 bits.
  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/game_session_ctrl.sv
// Arithmetic quiz session controller: shows BCD digits, collects a two-digit
// answer, scores it per player and tracks the global leader.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int ID_W        = 5,
  parameter int ROUNDS      = 3,
  parameter int MAX_SCORE   = 99,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    logged_in,
  input  logic                    game_start,
  input  logic                    load_input,
  input  logic [BCD_W-1:0]        player_input,
  input  logic [ID_W-1:0]         player_id,
  input  logic [4*NUM_DIGITS-1:0] rng_in,
  output logic [4*NUM_DIGITS-1:0] leds,
  output logic [BCD_W-1:0]        d10,
  output logic [BCD_W-1:0]        d1,
  output logic                    busy,
  output logic                    is_valid,
  output logic                    answer_ok,
  output logic                    personal_winner,
  output logic [ID_W-1:0]         global_winner,
  output logic [SCORE_W-1:0]      global_high
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RND_W = 4;

  state_t             r_state, w_next;
  logic [RND_W-1:0]   r_round;
  logic [TMR_W-1:0]   r_timer;
  logic [ID_W-1:0]    r_id;
  logic [BCD_W-1:0]   r_tens, r_ones;
  logic               r_timed_out;
  logic               r_pend;
  logic               r_new_ok;
  logic [SCORE_W-1:0] r_new_score;
  logic [SCORE_W-1:0] w_rd_data, w_new_score;
  logic [2*BCD_W-1:0] w_expect;
  logic               w_waiting, w_timeout, w_digit_ok, w_start;
  logic               w_last_round, w_correct, w_rd_en, w_wr_en;

  assign w_waiting    = (r_state == S_WAIT_T) || (r_state == S_WAIT_O);
  assign w_timeout    = w_waiting && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  assign w_digit_ok   = load_input && (player_input <= 4'd9);
  assign w_start      = game_start && logged_in;
  assign w_last_round = (r_round == RND_W'(ROUNDS - 1));
  assign w_expect     = to_bcd(bcd_digit_sum(SUM_W'(leds)));
  assign w_correct    = !r_timed_out && ({r_tens, r_ones} == w_expect);
  assign w_new_score  = w_correct ? sat_inc(w_rd_data, SCORE_W'(MAX_SCORE))
                                  : sat_dec(w_rd_data);

  score_ram #(.ID_W(ID_W)) u_score_ram (
    .clk       (clk),
    .rst_n     (reset),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_id),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_id),
    .i_wr_data (w_new_score)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; logout aborts before READ, timeout beats a late digit.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_WAIT_T;
      S_WAIT_T: begin
        if (!logged_in)      w_next = S_IDLE;
        else if (w_timeout)  w_next = S_READ;
        else if (w_digit_ok) w_next = S_WAIT_O;
      end
      S_WAIT_O: begin
        if (!logged_in)      w_next = S_IDLE;
        else if (w_timeout)  w_next = S_READ;
        else if (w_digit_ok) w_next = S_READ;
      end
      S_READ:   w_next = logged_in ? S_UPDATE : S_IDLE;
      S_UPDATE: w_next = (!logged_in || w_last_round) ? S_IDLE : S_WAIT_T;
      default:  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: busy flag and score table strobes.
  always_comb begin
    busy    = (r_state != S_IDLE);
    w_rd_en = (r_state == S_READ);
    w_wr_en = (r_state == S_UPDATE);
  end

  // Session datapath: latches, timer, round count and the registered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds            <= '0;
      r_id            <= '0;
      r_round         <= '0;
      r_timer         <= '0;
      r_tens          <= '0;
      r_ones          <= '0;
      r_timed_out     <= 1'b0;
      r_pend          <= 1'b0;
      r_new_ok        <= 1'b0;
      r_new_score     <= '0;
      is_valid        <= 1'b0;
      answer_ok       <= 1'b0;
      personal_winner <= 1'b0;
      d10             <= '0;
      d1              <= '0;
      global_high     <= '0;
      global_winner   <= '0;
    end else begin
      is_valid        <= 1'b0;
      personal_winner <= 1'b0;
      r_pend          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            leds        <= rng_in;
            r_id        <= player_id;
            r_round     <= '0;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
          end
        end
        S_WAIT_T, S_WAIT_O: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_timeout)                            r_timed_out <= 1'b1;
          else if (w_digit_ok && r_state == S_WAIT_T) r_tens    <= player_input;
          else if (w_digit_ok)                      r_ones      <= player_input;
        end
        S_UPDATE: begin
          r_new_score <= w_new_score;
          r_new_ok    <= w_correct;
          r_pend      <= 1'b1;
          r_round     <= r_round + RND_W'(1);
          if (w_next == S_WAIT_T) begin
            leds        <= rng_in;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
          end
        end
        default: ;
      endcase
      if (r_pend) begin
        is_valid       <= 1'b1;
        answer_ok      <= r_new_ok;
        {d10, d1}      <= to_bcd(r_new_score);
        if (r_new_score > global_high) begin
          global_high     <= r_new_score;
          global_winner   <= r_id;
          personal_winner <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: directed table, corner-case
// sequences and randomized sessions against a score-table reference model.
module tb_game_session_ctrl;

  localparam int TMO    = 40;
  localparam int ROUNDS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        logged_in, game_start, load_input;
  logic [3:0]  player_input;
  logic [4:0]  player_id;
  logic [15:0] rng_in;
  logic [15:0] leds;
  logic [3:0]  d10, d1;
  logic        busy, is_valid, answer_ok, personal_winner;
  logic [4:0]  global_winner;
  logic [6:0]  global_high;

  game_session_ctrl #(
    .NUM_DIGITS(4), .ID_W(5), .ROUNDS(ROUNDS), .MAX_SCORE(99), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .logged_in(logged_in), .game_start(game_start),
    .load_input(load_input), .player_input(player_input), .player_id(player_id),
    .rng_in(rng_in), .leds(leds), .d10(d10), .d1(d1), .busy(busy),
    .is_valid(is_valid), .answer_ok(answer_ok), .personal_winner(personal_winner),
    .global_winner(global_winner), .global_high(global_high)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: per-player scores and the current leader.
  int          mscore [32];
  int          mhigh = 0;
  int          mwin  = 0;
  logic [15:0] cur_rng;

  typedef struct {
    bit         seen;
    int         lat;
    logic       ok, pw, busy_after, valid_after;
    logic [3:0] d10, d1;
    logic [4:0] gw;
    logic [6:0] gh;
  } obs_t;

  typedef struct {
    int          id;
    logic [15:0] rng;
    int          t, o;
    bit          bad, tmo;
    int          e_ok, e_score, e_pw, e_gw, e_gh;
  } row_t;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int digit_sum(input logic [15:0] r);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(r[4*k +: 4]);
    return s;
  endfunction

  function automatic logic [15:0] rand_rng();
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Apply one rule of the game to the model and report the expected result.
  task automatic model_round(input int id, input logic [15:0] r, input int t, input int o,
                             input bit tmo, output int e_ok, output int e_score,
                             output int e_pw);
    bit good;
    good = !tmo && (t * 10 + o == digit_sum(r));
    if (good) mscore[id] = (mscore[id] >= 99) ? 99 : mscore[id] + 1;
    else      mscore[id] = (mscore[id] == 0) ? 0 : mscore[id] - 1;
    e_ok    = int'(good);
    e_score = mscore[id];
    e_pw    = int'(mscore[id] > mhigh);
    if (mscore[id] > mhigh) begin
      mhigh = mscore[id];
      mwin  = id;
    end
  endtask

  task automatic start_session(input int id, input logic [15:0] r);
    logged_in  = 1'b1;
    player_id  = 5'(id);
    rng_in     = r;
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    cur_rng    = r;
    check("start_busy", int'(busy), 1);
  endtask

  // Drive one answer (or let it time out) and capture the result cycle.
  task automatic play_round(input int t, input int o, input bit bad, input bit tmo,
                            input bit junk, input logic [15:0] next_rng, output obs_t ob);
    int limit;
    ob.seen = 0; ob.lat = 0; ob.ok = 0; ob.pw = 0; ob.busy_after = 0;
    ob.valid_after = 0; ob.d10 = 0; ob.d1 = 0; ob.gw = 0; ob.gh = 0;
    if (!tmo) begin
      if (junk) begin
        game_start = 1'b1;
        player_id  = 5'($urandom_range(0, 31));
        rng_in     = rand_rng();
      end
      if (bad) begin
        load_input = 1'b1; player_input = 4'(10 + $urandom_range(0, 5)); step();
      end
      load_input = 1'b1; player_input = 4'(t); step();
      load_input = 1'b1; player_input = 4'(o); step();
    end
    load_input = 1'b0;
    game_start = 1'b0;
    rng_in     = next_rng;
    limit = tmo ? TMO + 20 : 12;
    for (int i = 1; i <= limit && !ob.seen; i++) begin
      step();
      if (is_valid) begin
        ob.seen = 1; ob.lat = i; ob.ok = answer_ok; ob.pw = personal_winner;
        ob.d10 = d10; ob.d1 = d1; ob.gw = global_winner; ob.gh = global_high;
        ob.busy_after = busy;
      end
    end
    step();
    ob.valid_after = is_valid;
  endtask

  task automatic check_obs(input string p, input obs_t ob, input int e_lat, input int e_ok,
                           input int e_score, input int e_pw, input int e_gw,
                           input int e_gh, input int e_busy);
    check({p, "_seen"}, int'(ob.seen), 1);
    check({p, "_latency"}, ob.lat, e_lat);
    check({p, "_answer_ok"}, int'(ob.ok), e_ok);
    check({p, "_d10"}, int'(ob.d10), e_score / 10);
    check({p, "_d1"}, int'(ob.d1), e_score % 10);
    check({p, "_personal_winner"}, int'(ob.pw), e_pw);
    check({p, "_global_winner"}, int'(ob.gw), e_gw);
    check({p, "_global_high"}, int'(ob.gh), e_gh);
    check({p, "_busy_after"}, int'(ob.busy_after), e_busy);
    check({p, "_pulse_width"}, int'(ob.valid_after), 0);
  endtask

  // One model-checked session; rand_mode mixes wrong answers, bad digits and timeouts.
  task automatic model_session(input int id, input bit rand_mode, output obs_t last_ob);
    obs_t        ob;
    logic [15:0] nxt;
    int          t, o, sel, e_ok, e_score, e_pw, e_lat;
    bit          bad, tmo, junk;
    start_session(id, rand_rng());
    for (int k = 0; k < ROUNDS; k++) begin
      check("round_leds", int'(leds), int'(cur_rng));
      t = digit_sum(cur_rng) / 10;
      o = digit_sum(cur_rng) % 10;
      bad = 0; tmo = 0; junk = 0;
      if (rand_mode) begin
        sel  = int'($urandom_range(0, 9));
        tmo  = (sel == 0);
        if (sel == 1 || sel == 2) begin
          t = int'($urandom_range(0, 9));
          o = int'($urandom_range(0, 9));
        end
        bad  = ($urandom_range(0, 3) == 0);
        junk = ($urandom_range(0, 3) == 0);
      end
      nxt = (k == ROUNDS - 1) ? 16'h0 : rand_rng();
      play_round(t, o, bad, tmo, junk, nxt, ob);
      model_round(id, cur_rng, t, o, tmo, e_ok, e_score, e_pw);
      e_lat = !tmo ? 3 : (k == 0 ? TMO + 3 : TMO + 1);
      check_obs("model", ob, e_lat, e_ok, e_score, e_pw, mwin, mhigh,
                int'(k != ROUNDS - 1));
      cur_rng = nxt;
      last_ob = ob;
    end
  endtask

  row_t tbl [12];

  initial begin
    obs_t ob;
    int   e_ok, e_score, e_pw, e_lat;
    bit   seen;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t ob;
    int   e_ok, e_score, e_pw, e_lat;
    bit   seen;

    //         id  rng       t  o  bad tmo ok score pw gw gh
    tbl[0]  = '{5, 16'h1234, 1, 0, 0,  0,  1, 1,    1, 5, 1};
    tbl[1]  = '{5, 16'h1234, 1, 0, 1,  0,  1, 2,    1, 5, 2};
    tbl[2]  = '{5, 16'h9999, 3, 6, 0,  0,  1, 3,    1, 5, 3};
    tbl[3]  = '{7, 16'h0001, 0, 1, 0,  0,  1, 1,    0, 5, 3};
    tbl[4]  = '{7, 16'h0011, 0, 2, 0,  0,  1, 2,    0, 5, 3};
    tbl[5]  = '{7, 16'h0111, 0, 3, 0,  0,  1, 3,    0, 5, 3};
    tbl[6]  = '{0, 16'h1234, 9, 9, 0,  0,  0, 0,    0, 5, 3};
    tbl[7]  = '{0, 16'h5555, 2, 0, 0,  0,  1, 1,    0, 5, 3};
    tbl[8]  = '{0, 16'h0000, 0, 0, 0,  1,  0, 0,    0, 5, 3};
    tbl[9]  = '{5, 16'h0002, 0, 2, 0,  0,  1, 4,    1, 5, 4};
    tbl[10] = '{5, 16'h0003, 0, 3, 0,  0,  1, 5,    1, 5, 5};
    tbl[11] = '{5, 16'h0000, 0, 0, 0,  1,  0, 4,    0, 5, 5};

    for (int i = 0; i < 32; i++) mscore[i] = 0;
    reset = 1'b0; logged_in = 1'b0; game_start = 1'b0; load_input = 1'b0;
    player_input = '0; player_id = '0; rng_in = '0;
    step(); step();
    check("rst_busy", int'(busy), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_d10", int'(d10), 0);
    check("rst_d1", int'(d1), 0);
    check("rst_is_valid", int'(is_valid), 0);
    check("rst_answer_ok", int'(answer_ok), 0);
    check("rst_personal_winner", int'(personal_winner), 0);
    check("rst_global_winner", int'(global_winner), 0);
    check("rst_global_high", int'(global_high), 0);
    reset = 1'b1;
    step();

    // game_start without login is ignored.
    logged_in = 1'b0; game_start = 1'b1; rng_in = 16'h4321; step();
    game_start = 1'b0;
    check("nologin_busy", int'(busy), 0);
    check("nologin_leds", int'(leds), 0);

    // Directed table: four sessions of three rounds with hand-derived results.
    for (int r = 0; r < 12; r++) begin
      if (r % ROUNDS == 0) start_session(tbl[r].id, tbl[r].rng);
      check($sformatf("tbl%0d_leds", r), int'(leds), int'(tbl[r].rng));
      play_round(tbl[r].t, tbl[r].o, tbl[r].bad, tbl[r].tmo, 1'b0,
                 (r % ROUNDS == ROUNDS - 1) ? 16'h0 : tbl[r+1].rng, ob);
      model_round(tbl[r].id, tbl[r].rng, tbl[r].t, tbl[r].o, tbl[r].tmo,
                  e_ok, e_score, e_pw);
      e_lat = tbl[r].tmo ? TMO + 1 : 3;
      check_obs($sformatf("tbl%0d", r), ob, e_lat, tbl[r].e_ok, tbl[r].e_score,
                tbl[r].e_pw, tbl[r].e_gw, tbl[r].e_gh,
                int'(r % ROUNDS != ROUNDS - 1));
    end

    // Logout while waiting for the ones digit: abort, no result, score kept.
    start_session(7, 16'h1234);
    load_input = 1'b1; player_input = 4'd1; step();
    load_input = 1'b0; logged_in = 1'b0; step();
    check("abort_busy", int'(busy), 0);
    logged_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (is_valid) seen = 1;
    end
    check("abort_no_valid", int'(seen), 0);
    model_session(7, 1'b0, ob);

    // Reset in WAIT_T: everything returns to zero immediately, scores wiped.
    start_session(5, 16'h0042);
    step();
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_leds", int'(leds), 0);
    check("midrst_d1", int'(d1), 0);
    check("midrst_is_valid", int'(is_valid), 0);
    check("midrst_global_high", int'(global_high), 0);
    check("midrst_global_winner", int'(global_winner), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mscore[i] = 0;
    mhigh = 0; mwin = 0;
    step();
    model_session(5, 1'b0, ob);

    // Drive one player to the saturation ceiling.
    for (int s = 0; s < 34; s++) model_session(9, 1'b0, ob);
    check("sat_d10", int'(ob.d10), 9);
    check("sat_d1", int'(ob.d1), 9);
    check("sat_personal_winner", int'(ob.pw), 0);
    check("sat_answer_ok", int'(ob.ok), 1);

    // Randomized sessions over a small set of players.
    for (int s = 0; s < 16; s++) model_session(int'($urandom_range(0, 7)), 1'b1, ob);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
